waveform_readout: RTL

WAVEFORM_READOUT -- requirements
Module: waveform_readout

---
 rtl/waveform_readout.sv | 138 +++++++++++++
 1 files changed

// File: rtl/waveform_readout.sv
// rtl/waveform_readout.sv - trigger-windowed sample capture into an output FIFO with a valid/ready/last stream
// Optional build macro: WAVEFORM_READOUT_TIMESTAMP_EN prepends a cycle-count word to every event.
module waveform_readout #(
    parameter int P_DATA_WIDTH = 28,
    parameter int P_LEN_WIDTH  = 8,
    parameter int P_FIFO_AW    = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_DATA_WIDTH-1:0] stream_in,
    input  logic                    ptb_rdy,
    input  logic                    trig,
    input  logic [P_LEN_WIDTH-1:0]  window_len,
    output logic [P_DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic [15:0]             trig_dropped_cnt
);

    localparam int CW = P_LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
    state_t state;

    logic [CW-1:0]           total, cnt, len_eff, words;
    logic                    stage_valid, stage_last;
    logic [P_DATA_WIDTH-1:0] stage_data, src, first_data;
    logic [P_DATA_WIDTH:0]   mem [2**P_FIFO_AW];
    logic [P_FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic                    accept;

`ifdef WAVEFORM_READOUT_TIMESTAMP_EN
    // Samples run one cycle behind so the timestamp word can take the acceptance slot.
    logic [P_DATA_WIDTH-1:0] ts_cnt, stream_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt   <= '0;
            stream_d <= '0;
        end else begin
            ts_cnt   <= ts_cnt + 1'b1;
            stream_d <= stream_in;
        end
    end

    assign src        = stream_d;
    assign first_data = ts_cnt;
    assign words      = len_eff + CW'(1);
`else
    assign src        = stream_in;
    assign first_data = stream_in;
    assign words      = len_eff;
`endif

    assign len_eff = (window_len == '0) ? CW'(1) : {1'b0, window_len};
    assign accept  = (state == IDLE) && trig && ptb_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            total            <= '0;
            cnt              <= '0;
            stage_valid      <= 1'b0;
            stage_last       <= 1'b0;
            stage_data       <= '0;
            busy             <= 1'b0;
            trig_dropped_cnt <= '0;
        end else begin
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
            if (trig && !accept && trig_dropped_cnt != 16'hFFFF)
                trig_dropped_cnt <= trig_dropped_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        total       <= words;
                        cnt         <= CW'(1);
                        stage_valid <= 1'b1;
                        stage_data  <= first_data;
                        stage_last  <= (words == CW'(1));
                        state       <= (words == CW'(1)) ? DRAIN : CAPTURE;
                        busy        <= 1'b1;
                    end
                end
                CAPTURE: begin
                    stage_valid <= 1'b1;
                    stage_data  <= src;
                    stage_last  <= (cnt == total - CW'(1));
                    cnt         <= cnt + CW'(1);
                    if (cnt == total - CW'(1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (m_tvalid && m_tready && m_tlast) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (stage_valid)
            mem[wr_ptr] <= {stage_last, stage_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_ptr <= '0;
        else if (stage_valid)
            wr_ptr <= wr_ptr + 1'b1;
    end

    // First-word-fall-through output register; reloads only when empty or accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
        end else if (!m_tvalid || m_tready) begin
            if (wr_ptr != rd_ptr) begin
                {m_tlast, m_tdata} <= mem[rd_ptr];
                m_tvalid           <= 1'b1;
                rd_ptr             <= rd_ptr + 1'b1;
            end else begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end

endmodule
